// File: rtl/alu_exec_ctrl.sv
// Four-state instruction sequencer around an external combinational ALU.
// It owns a 16 x 16-bit register file and the processor status register.
module alu_exec_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_opcode,
    input  logic [3:0]  in_rdest,
    input  logic [3:0]  in_rsrc,
    input  logic        in_imm_en,
    input  logic [15:0] in_imm,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [4:0]  alu_opcode,
    output logic        alu_cin,
    input  logic [15:0] alu_c,
    input  logic [4:0]  alu_flags,
    output logic [4:0]  psr,
    output logic        done,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [4:0]  op_reg;
    logic [3:0]  rdest_reg;
    logic [3:0]  rsrc_reg;
    logic        imm_en_reg;
    logic [15:0] imm_reg;
    logic [15:0] opa_reg;
    logic [15:0] opb_reg;
    logic [15:0] res_reg;
    logic [4:0]  flags_reg;
    logic [4:0]  psr_reg;
    logic [15:0] rf_reg [16];
    logic [15:0] rf_we;
    logic        wr_class;
    logic        flag_class;
    logic        accept;

    assign accept   = in_valid && (state_reg == S_IDLE);
    assign psr      = psr_reg;
    assign dbg_data = rf_reg[dbg_addr];

    // Opcode classes: which results reach the register file and which reach psr.
    always_comb begin
        wr_class   = 1'b0;
        flag_class = 1'b0;
        case (op_reg)
            5'b00101, 5'b00111, 5'b01001: begin
                wr_class   = 1'b1;
                flag_class = 1'b1;
            end
            5'b00110, 5'b01111, 5'b00001, 5'b00010, 5'b00011,
            5'b00100, 5'b01100, 5'b10011, 5'b10111: wr_class = 1'b1;
            5'b01011: flag_class = 1'b1;
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_rf_we
            assign rf_we[gi] = (state_reg == S_WB) && wr_class && (rdest_reg == 4'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                rf_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (rf_we[i]) begin
                    rf_reg[i] <= res_reg;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_reg     <= '0;
            rdest_reg  <= '0;
            rsrc_reg   <= '0;
            imm_en_reg <= 1'b0;
            imm_reg    <= '0;
            opa_reg    <= '0;
            opb_reg    <= '0;
            res_reg    <= '0;
            flags_reg  <= '0;
            psr_reg    <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        op_reg     <= in_opcode;
                        rdest_reg  <= in_rdest;
                        rsrc_reg   <= in_rsrc;
                        imm_en_reg <= in_imm_en;
                        imm_reg    <= in_imm;
                    end
                end
                S_FETCH: begin
                    // Both operands sample the register file before any write of this instruction.
                    opa_reg <= rf_reg[rdest_reg];
                    opb_reg <= imm_en_reg ? imm_reg : rf_reg[rsrc_reg];
                end
                S_EXEC: begin
                    res_reg   <= alu_c;
                    flags_reg <= alu_flags;
                end
                S_WB: begin
                    if (flag_class) begin
                        psr_reg <= flags_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        done       = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = '0;
        alu_cin    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: state_next = S_EXEC;
            S_EXEC: begin
                alu_a      = opa_reg;
                alu_b      = opb_reg;
                alu_opcode = op_reg;
                alu_cin    = psr_reg[4];
                state_next = S_WB;
            end
            S_WB: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a small behavioural ALU attached to
// the alu_* ports; expected register and psr values are hand-computed.
module tb_alu_exec_ctrl;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [3:0]  in_rdest;
    logic [3:0]  in_rsrc;
    logic        in_imm_en;
    logic [15:0] in_imm;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [4:0]  alu_opcode;
    logic        alu_cin;
    logic [15:0] alu_c;
    logic [4:0]  alu_flags;
    logic [4:0]  psr;
    logic        done;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checks   = 0;
    int failures = 0;
    logic [15:0] shadow [16];
    logic [16:0] m_sum;

    typedef struct packed {
        logic [4:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic        ie;
        logic [15:0] imm;
        logic [15:0] exp_val;
        logic [4:0]  exp_psr;
        logic        exp_cin;
    } vec_t;

    vec_t vecs [23];
    vec_t fa [8];

    alu_exec_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rdest   (in_rdest),
        .in_rsrc    (in_rsrc),
        .in_imm_en  (in_imm_en),
        .in_imm     (in_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_cin    (alu_cin),
        .alu_c      (alu_c),
        .alu_flags  (alu_flags),
        .psr        (psr),
        .done       (done),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU, flags {C,L,F,Z,N}.
    always_comb begin
        m_sum     = 17'd0;
        alu_c     = 16'd0;
        alu_flags = 5'd0;
        case (alu_opcode)
            5'b00101, 5'b00110: m_sum = {1'b0, alu_a} + {1'b0, alu_b};
            5'b00111, 5'b01111: m_sum = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
            5'b01001, 5'b01011: m_sum = {1'b0, alu_a} - {1'b0, alu_b};
            5'b00001: m_sum = {1'b0, alu_a & alu_b};
            5'b00010: m_sum = {1'b0, alu_a | alu_b};
            5'b00011: m_sum = {1'b0, alu_a ^ alu_b};
            5'b00100: m_sum = {1'b0, ~alu_a};
            5'b01100: m_sum = {1'b0, alu_a << alu_b[3:0]};
            5'b10011: m_sum = {1'b0, alu_a >> alu_b[3:0]};
            5'b10111: m_sum = {1'b0, 16'($signed(alu_a) >>> alu_b[3:0])};
            default: ;
        endcase
        alu_c        = m_sum[15:0];
        alu_flags[1] = (m_sum[15:0] == 16'd0);
        alu_flags[0] = m_sum[15];
        case (alu_opcode)
            5'b00101, 5'b00110, 5'b00111, 5'b01111: begin
                alu_flags[4] = m_sum[16];
                alu_flags[2] = (alu_a[15] == alu_b[15]) && (m_sum[15] != alu_a[15]);
            end
            5'b01001: begin
                alu_flags[4] = (alu_a < alu_b);
                alu_flags[2] = (alu_a[15] != alu_b[15]) && (m_sum[15] != alu_a[15]);
            end
            5'b01011: begin
                alu_flags[4] = 1'b0;
                alu_flags[3] = (alu_a < alu_b);
                alu_flags[2] = 1'b0;
                alu_flags[1] = (alu_a == alu_b);
                alu_flags[0] = ($signed(alu_a) < $signed(alu_b));
            end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [15:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    // Issue one instruction and walk it through FETCH/EXEC/WB/IDLE on falling edges.
    task automatic run_instr(input vec_t v);
        int n;
        logic [15:0] rv;
        @(negedge clk);
        in_valid  = 1'b1;
        in_opcode = v.op;
        in_rdest  = v.rd;
        in_rsrc   = v.rs;
        in_imm_en = v.ie;
        in_imm    = v.imm;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("fetch_done_low", 32'(done), 32'd0);
        chk("fetch_alu_quiet", {10'd0, alu_opcode, alu_cin, alu_a}, 32'd0);
        @(negedge clk);
        chk("exec_opcode", 32'(alu_opcode), 32'(v.op));
        chk("exec_cin", 32'(alu_cin), 32'(v.exp_cin));
        chk("exec_done_low", 32'(done), 32'd0);
        @(negedge clk);
        chk("wb_done", 32'(done), 32'd1);
        read_reg(v.rd, rv);
        chk("wb_dbg_old", 32'(rv), 32'(shadow[v.rd]));
        @(negedge clk);
        chk("idle_done_low", 32'(done), 32'd0);
        chk("idle_ready", 32'(in_ready), 32'd1);
        read_reg(v.rd, rv);
        chk("reg_result", 32'(rv), 32'(v.exp_val));
        chk("psr", 32'(psr), 32'(v.exp_psr));
        shadow[v.rd] = v.exp_val;
        $display("txn op=%b rd=%0d rs=%0d ie=%0d imm=%h -> reg=%h psr=%b", v.op, v.rd, v.rs, v.ie, v.imm, rv, psr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rv;
        int done_cnt;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_rdest  = '0;
        in_rsrc   = '0;
        in_imm_en = 1'b0;
        in_imm    = '0;
        dbg_addr  = '0;
        for (int i = 0; i < 16; i++) shadow[i] = 16'd0;

        //            op        rd    rs    ie    imm       exp_val   exp_psr   cin
        vecs[0]  = '{5'b00101, 4'd1,  4'd0,  1'b1, 16'h7FFF, 16'h7FFF, 5'b00000, 1'b0};
        vecs[1]  = '{5'b00101, 4'd1,  4'd0,  1'b1, 16'h0001, 16'h8000, 5'b00101, 1'b0};
        vecs[2]  = '{5'b00110, 4'd2,  4'd0,  1'b1, 16'hFFFF, 16'hFFFF, 5'b00101, 1'b0};
        vecs[3]  = '{5'b00101, 4'd2,  4'd0,  1'b1, 16'h0001, 16'h0000, 5'b10010, 1'b0};
        vecs[4]  = '{5'b00111, 4'd3,  4'd0,  1'b1, 16'h0000, 16'h0001, 5'b00000, 1'b1};
        vecs[5]  = '{5'b00110, 4'd4,  4'd0,  1'b1, 16'h0005, 16'h0005, 5'b00000, 1'b0};
        vecs[6]  = '{5'b00110, 4'd5,  4'd0,  1'b1, 16'h0005, 16'h0005, 5'b00000, 1'b0};
        vecs[7]  = '{5'b01011, 4'd4,  4'd5,  1'b0, 16'h0000, 16'h0005, 5'b00010, 1'b0};
        vecs[8]  = '{5'b00001, 4'd4,  4'd5,  1'b0, 16'h0000, 16'h0005, 5'b00010, 1'b0};
        vecs[9]  = '{5'b00110, 4'd6,  4'd0,  1'b1, 16'h8000, 16'h8000, 5'b00010, 1'b0};
        vecs[10] = '{5'b10111, 4'd6,  4'd0,  1'b1, 16'h0004, 16'hF800, 5'b00010, 1'b0};
        vecs[11] = '{5'b00110, 4'd8,  4'd0,  1'b1, 16'h8000, 16'h8000, 5'b00010, 1'b0};
        vecs[12] = '{5'b10011, 4'd8,  4'd0,  1'b1, 16'h0004, 16'h0800, 5'b00010, 1'b0};
        vecs[13] = '{5'b01001, 4'd9,  4'd0,  1'b1, 16'h0001, 16'hFFFF, 5'b10001, 1'b0};
        vecs[14] = '{5'b00011, 4'd8,  4'd8,  1'b0, 16'h0000, 16'h0000, 5'b10001, 1'b1};
        vecs[15] = '{5'b11111, 4'd1,  4'd0,  1'b1, 16'h0005, 16'h8000, 5'b10001, 1'b1};
        vecs[16] = '{5'b00000, 4'd1,  4'd0,  1'b1, 16'h0005, 16'h8000, 5'b10001, 1'b1};
        vecs[17] = '{5'b00100, 4'd10, 4'd0,  1'b1, 16'h0000, 16'hFFFF, 5'b10001, 1'b1};
        vecs[18] = '{5'b01100, 4'd10, 4'd0,  1'b1, 16'h0004, 16'hFFF0, 5'b10001, 1'b1};
        vecs[19] = '{5'b01111, 4'd10, 4'd0,  1'b1, 16'h000F, 16'h0000, 5'b10001, 1'b1};
        vecs[20] = '{5'b00010, 4'd10, 4'd9,  1'b0, 16'h0000, 16'hFFFF, 5'b10001, 1'b1};
        vecs[21] = '{5'b01011, 4'd9,  4'd10, 1'b0, 16'h0000, 16'hFFFF, 5'b00010, 1'b1};
        vecs[22] = '{5'b01001, 4'd1,  4'd2,  1'b0, 16'h0000, 16'h8000, 5'b00001, 1'b0};

        fa[0] = '{5'b00110, 4'd11, 4'd0, 1'b1, 16'h0011, 16'h0, 5'b0, 1'b0};
        fa[1] = '{5'b00110, 4'd12, 4'd0, 1'b1, 16'h0022, 16'h0, 5'b0, 1'b0};
        fa[2] = '{5'b00110, 4'd13, 4'd0, 1'b1, 16'h0033, 16'h0, 5'b0, 1'b0};
        fa[3] = '{5'b00110, 4'd11, 4'd0, 1'b1, 16'h0044, 16'h0, 5'b0, 1'b0};
        fa[4] = '{5'b00110, 4'd14, 4'd0, 1'b1, 16'h0055, 16'h0, 5'b0, 1'b0};
        fa[5] = fa[1];
        fa[6] = fa[2];
        fa[7] = fa[3];

        // Reset state, observed while reset is still asserted.
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_psr", 32'(psr), 32'd0);
        chk("rst_alu", {10'd0, alu_opcode, alu_cin, alu_b}, 32'd0);
        read_reg(4'd15, rv);
        chk("rst_r15", 32'(rv), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            run_instr(vecs[i]);
        end
        read_reg(4'd5, rv);
        chk("cmp_keeps_r5", 32'(rv), 32'h5);

        // in_valid held high with fields changing every cycle.
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (k < 8) begin
                in_valid  = 1'b1;
                in_opcode = fa[k].op;
                in_rdest  = fa[k].rd;
                in_rsrc   = fa[k].rs;
                in_imm_en = fa[k].ie;
                in_imm    = fa[k].imm;
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("hold_done_count", 32'(done_cnt), 32'd2);
        read_reg(4'd11, rv);
        chk("hold_r11", 32'(rv), 32'h0011);
        read_reg(4'd12, rv);
        chk("hold_r12", 32'(rv), 32'h0000);
        read_reg(4'd13, rv);
        chk("hold_r13", 32'(rv), 32'h0000);
        read_reg(4'd14, rv);
        chk("hold_r14", 32'(rv), 32'h0055);
        $display("txn held-valid sequence done_pulses=%0d", done_cnt);

        // Reset asserted during WB of ADD R7 aborts the write.
        @(negedge clk);
        in_valid  = 1'b1;
        in_opcode = 5'b00101;
        in_rdest  = 4'd7;
        in_rsrc   = 4'd0;
        in_imm_en = 1'b1;
        in_imm    = 16'h1234;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_in_wb", 32'(done), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_ready", 32'(in_ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_psr", 32'(psr), 32'd0);
        read_reg(4'd1, rv);
        chk("abort_r1_cleared", 32'(rv), 32'd0);
        @(negedge clk);
        read_reg(4'd7, rv);
        chk("abort_r7", 32'(rv), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) shadow[i] = 16'd0;
        $display("txn reset during WB r7=%h psr=%b", rv, psr);
        run_instr('{5'b00101, 4'd7, 4'd0, 1'b1, 16'h0003, 16'h0003, 5'b00000, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_exec_ctrl.md
ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 Parameters: none; data width fixed at 16 bits, register file fixed at 16 entries.
REQ-002 clk  in  1  sole clock; all state SHALL change on the rising edge only.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  instruction offered.
REQ-005 in_ready  out  1  high only in IDLE; an instruction is accepted when in_valid & in_ready at a rising edge.
REQ-006 in_opcode  in  5  ALU opcode.
REQ-007 in_rdest / in_rsrc  in  4 each  destination/first-operand register and second-operand register.
REQ-008 in_imm_en  in  1  selects in_imm instead of R[in_rsrc] as operand B.
REQ-009 in_imm  in  16  immediate, used unextended.
REQ-010 alu_a, alu_b  out  16 each; alu_opcode  out  5; alu_cin  out  1  drive the combinational ALU.
REQ-011 alu_c  in  16; alu_flags  in  5  ALU result and flags {C,L,F,Z,N} at bits [4:0].
REQ-012 psr  out  5  registered processor status, same bit order as alu_flags.
REQ-013 done  out  1  one-cycle pulse, high during WB.
REQ-014 dbg_addr  in  4; dbg_data  out  16  combinational read of R[dbg_addr].

Function
REQ-015 FSM states: IDLE -> FETCH -> EXEC -> WB -> IDLE; each non-IDLE state SHALL last exactly one cycle, giving one instruction per 4 cycles.
REQ-016 IDLE: on acceptance, latch opcode, rdest, rsrc, imm_en, imm and go to FETCH; otherwise remain.
REQ-017 FETCH: latch opA = R[rdest], opB = imm_en ? imm : R[rsrc].
REQ-018 EXEC: alu_a = opA, alu_b = opB, alu_opcode = latched opcode, alu_cin = psr[4]; latch alu_c and alu_flags at end of cycle.
REQ-019 Outside EXEC, alu_a, alu_b, alu_opcode SHALL be 0 (opcode 00000 = WAIT) and alu_cin 0.
REQ-020 WB: write latched result to R[rdest] at the closing edge for write-class opcodes: ADD 00101, ADDU 00110, ADDC 00111, ADDCU 01111, SUB 01001, AND 00001, OR 00010, XOR 00011, NOT 00100, LSH 01100, RSH 10011, ARSH 10111.
REQ-021 WB: psr SHALL load latched flags only for ADD, ADDC, SUB, CMP (01011); all other opcodes leave psr unchanged.
REQ-022 CMP SHALL not write the register file; WAIT and any unlisted opcode SHALL write neither register file nor psr but still traverse all states and pulse done.
REQ-023 in_valid while not in IDLE SHALL be ignored; upstream holds the instruction until in_ready.
REQ-024 rdest == rsrc is legal; both operands read the pre-write value.
REQ-025 A dbg_addr read of the register being written in WB SHALL return the old value until the edge.
REQ-026 Adds wrap modulo 2^16; carry only reported via psr[4].

Reset
REQ-027 reset_n low SHALL immediately force state IDLE, all 16 registers 0, psr 0, done 0, latched instruction/operands/result 0, ALU drive outputs 0; in_ready SHALL be 1 while reset_n is low.
REQ-028 Reset asserted mid-instruction SHALL abort it with no register or psr write, even in WB.

Verification
REQ-029 Reset, then ADD imm R1=0+0x7FFF, then ADD imm R1+=1 -> R1=0x8000, psr=00101 (F,N), done once per instruction, 4-cycle spacing.
REQ-030 R2=0xFFFF via ADDU imm; ADD imm R2+=1 -> R2=0x0000, psr=10010 (C,Z); next ADDC imm R3=0+0 -> alu_cin=1 in EXEC, R3=0x0001.
REQ-031 R4=5, R5=5; CMP R4,R5 -> psr Z=1, R4/R5 unchanged; then AND R4,R5 -> R4=5, psr unchanged.
REQ-032 R6=0x8000; ARSH imm 4 -> R6=0xF800; RSH imm 4 on 0x8000 -> 0x0800.
REQ-033 in_valid held high continuously with changing fields -> only fields present when in_ready=1 accepted; opcode 11111 -> no writes, done pulses.
REQ-034 reset_n dropped during WB of ADD to R7 -> R7=0, psr=0, state IDLE, in_ready=1.
